amq_dp_ctrl: RTL



---
 rtl/amq_dp_ctrl.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/amq_dp_ctrl.sv
// Control sequencer for the AmQ datapath: LOAD fills a variable from D_IN,
// AMQ sweeps an operand through the adder with a Qns ROM constant and writes it back.
module amq_dp_ctrl #(
  parameter int NUM_WORDS = 4,
  parameter int QNS_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cmd,
  input  logic       add_sub_in,
  input  logic [2:0] rd_off_in,
  input  logic [2:0] wr_off_in,
  input  logic [4:0] qns_base_in,
  input  logic       mem_cfg_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic       carry_out,
  input  logic       C_OUT_DPq,
  output logic       CARRY_SEL,
  output logic       S_REG_RST,
  output logic       S_REG_EN,
  output logic       WB_PHASE,
  output logic       WE_RAM,
  output logic       MEM_CONFIG,
  output logic       ADD_sub,
  output logic [1:0] WB_ADDR,
  output logic [1:0] RAM_ADDR,
  output logic [2:0] WR_VAR_OFFSET,
  output logic [2:0] RD_VAR_OFFSET,
  output logic [4:0] Qns_ADDR_FINAL
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRIME = 3'd2,
    ST_SWEEP = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] LAST_K   = 2'(NUM_WORDS - 1);
  // The ROM is addressed QNS_LAT words ahead so its output lines up with RAM word k.
  localparam logic [4:0] QNS_LEAD = 5'(QNS_LAT);

  state_t     state_r, state_s;
  logic [1:0] k_r, k_s;
  logic       lat_add_sub_r, lat_add_sub_s, lat_mem_cfg_r, lat_mem_cfg_s;
  logic [2:0] lat_rd_off_r, lat_rd_off_s, lat_wr_off_r, lat_wr_off_s;
  logic [4:0] lat_base_r, lat_base_s;

  logic       busy_r, busy_s, done_r, done_s, in_ready_r, in_ready_s;
  logic       carry_r, carry_s, carry_sel_r, carry_sel_s;
  logic       s_reg_rst_r, s_reg_rst_s, s_reg_en_r, s_reg_en_s;
  logic       wb_phase_r, wb_phase_s, we_r, we_s;
  logic       mem_config_r, mem_config_s, add_sub_r, add_sub_s;
  logic [1:0] wb_addr_r, wb_addr_s, ram_addr_r, ram_addr_s;
  logic [2:0] wr_var_offset_r, wr_var_offset_s, rd_var_offset_r, rd_var_offset_s;
  logic [4:0] qns_addr_r, qns_addr_s;

  // Next-state, word counter and command latch.
  always_comb begin
    state_s       = state_r;
    k_s           = k_r;
    lat_add_sub_s = lat_add_sub_r;
    lat_mem_cfg_s = lat_mem_cfg_r;
    lat_rd_off_s  = lat_rd_off_r;
    lat_wr_off_s  = lat_wr_off_r;
    lat_base_s    = lat_base_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          lat_add_sub_s = add_sub_in;
          lat_mem_cfg_s = mem_cfg_in;
          lat_rd_off_s  = rd_off_in;
          lat_wr_off_s  = wr_off_in;
          lat_base_s    = qns_base_in;
          state_s       = cmd ? ST_PRIME : ST_LOAD;
          k_s           = 2'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (in_valid && in_ready_r) begin
          if (k_r == LAST_K) begin
            state_s = ST_DONE;
            k_s     = 2'd0;
          end else begin
            k_s = k_r + 2'd1;
          end
        end else begin
          k_s = k_r;
        end
      end
      ST_PRIME: begin
        state_s = ST_SWEEP;
        k_s     = 2'd0;
      end
      ST_SWEEP: begin
        if (k_r == LAST_K) begin
          state_s = ST_FLUSH;
          k_s     = 2'd0;
        end else begin
          k_s = k_r + 2'd1;
        end
      end
      ST_FLUSH: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so every pin comes straight from a flop.
  always_comb begin
    busy_s      = 1'b0;
    done_s      = 1'b0;
    in_ready_s  = 1'b0;
    carry_sel_s = 1'b0;
    s_reg_rst_s = 1'b0;
    s_reg_en_s  = 1'b0;
    wb_phase_s  = 1'b0;
    we_s        = 1'b0;
    wb_addr_s   = 2'd0;
    ram_addr_s  = 2'd0;
    qns_addr_s  = 5'd0;
    carry_s     = (state_r == ST_FLUSH) ? C_OUT_DPq : carry_r;
    case (state_s)
      ST_LOAD: begin
        busy_s     = 1'b1;
        in_ready_s = 1'b1;
        wb_addr_s  = k_s;
      end
      ST_PRIME: begin
        busy_s      = 1'b1;
        s_reg_rst_s = 1'b1;
        qns_addr_s  = lat_base_s;
      end
      ST_SWEEP: begin
        busy_s      = 1'b1;
        ram_addr_s  = k_s;
        s_reg_en_s  = 1'b1;
        carry_sel_s = (k_s != 2'd0);
        qns_addr_s  = lat_base_s + {3'b000, k_s} + QNS_LEAD;
        // Write-back trails the adder by one word.
        if (k_s != 2'd0) begin
          wb_phase_s = 1'b1;
          we_s       = 1'b1;
          wb_addr_s  = k_s - 2'd1;
        end else begin
          we_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        busy_s     = 1'b1;
        wb_phase_s = 1'b1;
        we_s       = 1'b1;
        wb_addr_s  = LAST_K;
      end
      ST_DONE: done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
    if (busy_s) begin
      mem_config_s    = lat_mem_cfg_s;
      add_sub_s       = lat_add_sub_s;
      wr_var_offset_s = lat_wr_off_s;
      rd_var_offset_s = lat_rd_off_s;
    end else begin
      mem_config_s    = 1'b0;
      add_sub_s       = 1'b0;
      wr_var_offset_s = 3'd0;
      rd_var_offset_s = 3'd0;
    end
  end

  // State, latch and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      k_r             <= 2'd0;
      lat_add_sub_r   <= 1'b0;
      lat_mem_cfg_r   <= 1'b0;
      lat_rd_off_r    <= 3'd0;
      lat_wr_off_r    <= 3'd0;
      lat_base_r      <= 5'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      in_ready_r      <= 1'b0;
      carry_r         <= 1'b0;
      carry_sel_r     <= 1'b0;
      s_reg_rst_r     <= 1'b0;
      s_reg_en_r      <= 1'b0;
      wb_phase_r      <= 1'b0;
      we_r            <= 1'b0;
      mem_config_r    <= 1'b0;
      add_sub_r       <= 1'b0;
      wb_addr_r       <= 2'd0;
      ram_addr_r      <= 2'd0;
      wr_var_offset_r <= 3'd0;
      rd_var_offset_r <= 3'd0;
      qns_addr_r      <= 5'd0;
    end else begin
      state_r         <= state_s;
      k_r             <= k_s;
      lat_add_sub_r   <= lat_add_sub_s;
      lat_mem_cfg_r   <= lat_mem_cfg_s;
      lat_rd_off_r    <= lat_rd_off_s;
      lat_wr_off_r    <= lat_wr_off_s;
      lat_base_r      <= lat_base_s;
      busy_r          <= busy_s;
      done_r          <= done_s;
      in_ready_r      <= in_ready_s;
      carry_r         <= carry_s;
      carry_sel_r     <= carry_sel_s;
      s_reg_rst_r     <= s_reg_rst_s;
      s_reg_en_r      <= s_reg_en_s;
      wb_phase_r      <= wb_phase_s;
      we_r            <= we_s;
      mem_config_r    <= mem_config_s;
      add_sub_r       <= add_sub_s;
      wb_addr_r       <= wb_addr_s;
      ram_addr_r      <= ram_addr_s;
      wr_var_offset_r <= wr_var_offset_s;
      rd_var_offset_r <= rd_var_offset_s;
      qns_addr_r      <= qns_addr_s;
    end
  end

  // LOAD beats write in the same cycle they are accepted.
  assign WE_RAM         = we_r | (in_valid & in_ready_r);
  assign in_ready       = in_ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign carry_out      = carry_r;
  assign CARRY_SEL      = carry_sel_r;
  assign S_REG_RST      = s_reg_rst_r;
  assign S_REG_EN       = s_reg_en_r;
  assign WB_PHASE       = wb_phase_r;
  assign MEM_CONFIG     = mem_config_r;
  assign ADD_sub        = add_sub_r;
  assign WB_ADDR        = wb_addr_r;
  assign RAM_ADDR       = ram_addr_r;
  assign WR_VAR_OFFSET  = wr_var_offset_r;
  assign RD_VAR_OFFSET  = rd_var_offset_r;
  assign Qns_ADDR_FINAL = qns_addr_r;

endmodule
